fir_stream_engine: RTL
======================

Name: fir_stream_engine

Overview:
- FIR compute stage sitting directly in front of the two 11-word BRAM instances (tap RAM, data RAM).
- Accepts input samples on an AXI-Stream slave and writes each one into the data RAM, which it runs as a circular shift buffer.
- Reads coefficients and history back through the BRAM ports, multiply-accumulates over all taps, and emits one result per input on an AXI-Stream master.
- Tap RAM is loaded elsewhere; this block only reads it.

Parameters:
- NUM_TAPS, 11, number of taps; equals BRAM depth in words.
- DW, 32, sample, coefficient and accumulator width.
- AW, 12, BRAM byte-address width (word index = A>>2).

Ports:
- axis_clk  in  1  sole clock, rising edge.
- axis_rst  in  1  asynchronous, active-high reset.
- ap_start  in  1  start pulse; sampled only in IDLE.
- data_length  in  32  number of samples in the run; sampled on ap_start.
- ap_idle  out  1  high in IDLE.
- ap_done  out  1  one-cycle pulse at end of run.
- ss_tvalid  in  1  input sample valid.
- ss_tdata  in  DW  input sample.
- ss_tlast  in  1  accepted but ignored for control.
- ss_tready  out  1  input ready.
- sm_tvalid  out  1  output valid.
- sm_tdata  out  DW  FIR result.
- sm_tlast  out  1  high with the final result of the run.
- sm_tready  in  1  downstream ready.
- tap_EN  out  1  tap RAM enable.
- tap_WE  out  4  tap RAM byte write enables; tied to 0.
- tap_A  out  AW  tap RAM byte address.
- tap_Do  in  DW  tap RAM read data.
- data_EN  out  1  data RAM enable.
- data_WE  out  4  data RAM byte write enables.
- data_A  out  AW  data RAM byte address.
- data_Di  out  DW  data RAM write data.
- data_Do  in  DW  data RAM read data.

Behaviour:
- BRAM contract: write is synchronous on the cycle EN=1 and WE=4'hF. Read data for address A presented in cycle k appears on Do in cycle k+1.

Reset (async, axis_rst=1):
- State goes to IDLE.
- ap_idle=1. ap_done, ss_tready, sm_tvalid, sm_tlast = 0. sm_tdata = 0.
- All EN/WE = 0; all addresses = 0; data_Di = 0.
- wr_ptr, sample count and accumulator = 0.
- Reset mid-run abandons the run; no ap_done is issued.

States:
- IDLE: on ap_start=1, latch data_length, wr_ptr=0, go to CLEAR.
- CLEAR: NUM_TAPS cycles writing 0 to word indices 0..10 (data_EN=1, data_WE=F). Then go to IN if data_length!=0, else DONE.
- IN: ss_tready=1. On ss_tvalid & ss_tready, write ss_tdata to word wr_ptr in the same cycle, then go to MAC.
- MAC: cycles i=0..NUM_TAPS-1 issue tap_A=i*4 and data_A=((wr_ptr−i) mod 11)*4, with both EN=1 and WE=0.
  - Cycles 1..NUM_TAPS: acc += tap_Do*data_Do, using the low DW bits of the product and wrapping modulo 2^DW (signed two's-complement is bit-identical).
  - acc is cleared on MAC entry.
  - MAC lasts NUM_TAPS+1 = 12 cycles, then go to OUT.
- OUT: sm_tvalid=1 and sm_tdata=acc, both held stable until sm_tready. sm_tlast=1 iff count==data_length−1.
  - On handshake: count++, and wr_ptr advances to (wr_ptr+1) mod 11, wrapping 10→0.
  - Go to DONE if this was the last sample, else IN.
- DONE: ap_done=1 for exactly one cycle, then IDLE.

Timing:
- Latency: sample accepted in cycle t → sm_tvalid first high in cycle t+13.
- Throughput: at most one sample per 14 cycles with no backpressure.
- ss_tready is 0 outside IN; no input is accepted during MAC or OUT.
- ap_start outside IDLE is ignored.
- sm_tready held low stalls indefinitely with no data loss.

Decomposition:
- Shared include fir_defs.vh holds:
  - state encodings IDLE/CLEAR/IN/MAC/OUT/DONE;
  - NUM_TAPS;
  - the BRAM write-enable constants (4'hF, 4'h0).
- One natural sub-module, fir_addr_gen. It owns wr_ptr, the tap index and the modulo-11 data index, and produces tap_A/data_A. The FSM and MAC stay in the top.

Test Plan:
- All taps=1, data_length=5, inputs 1,2,3,4,5 → outputs 1,3,6,10,15; sm_tlast only on 15; one ap_done pulse.
- Taps [0,−10,−9,23,56,63,56,23,−9,−10,0], impulse input 1 followed by ten 0s (data_length=11) → outputs equal the tap sequence in order.
- All taps=1, 25 inputs of 1 → outputs 1..11, then 11 repeated (checks wrap 10→0 and history reuse); second run after ap_done → CLEAR zeroes history, so outputs restart at 1.
- Backpressure: sm_tready=0 for 20 cycles in OUT → sm_tdata/sm_tvalid stable, ss_tready=0 throughout, no sample lost.
- data_length=0 → CLEAR, then ap_done pulse, no sm_tvalid, ss_tready never high; ap_start while busy is ignored.
- Assert axis_rst during MAC → outputs return to reset values immediately (asynchronously); after release ap_idle=1 and a fresh run produces correct results.

Source files
------------

// File: rtl/fir_stream_engine_pkg.sv
// Shared definitions for the FIR stream engine: controller states, tap count and
// BRAM write-enable constants.
package fir_stream_engine_pkg;

  localparam int unsigned NUM_TAPS_DEFAULT = 11;

  localparam logic [3:0] WE_ALL  = 4'hF;
  localparam logic [3:0] WE_NONE = 4'h0;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StIn,
    StMac,
    StOut,
    StDone
  } state_e;

endpackage

// File: rtl/fir_stream_engine_addr_gen.sv
// Address generator: owns the circular write pointer and the per-cycle index
// used for CLEAR and MAC, and turns them into BRAM byte addresses.
module fir_stream_engine_addr_gen #(
  parameter int unsigned NUM_TAPS = 11,
  parameter int unsigned AW       = 12,
  parameter int unsigned IW       = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_ptr_clr,
  input  logic          i_ptr_adv,
  input  logic          i_idx_clr,
  input  logic          i_idx_inc,
  output logic [IW-1:0] o_idx,
  output logic [AW-1:0] o_wr_a,
  output logic [AW-1:0] o_idx_a,
  output logic [AW-1:0] o_hist_a
);

  logic [IW-1:0] r_wr_ptr;
  logic [IW-1:0] r_idx;
  logic [IW:0]   w_hist_ext;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_idx    <= '0;
    end else begin
      if (i_ptr_clr) begin
        r_wr_ptr <= '0;
      end else if (i_ptr_adv) begin
        r_wr_ptr <= (r_wr_ptr == IW'(NUM_TAPS - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (i_idx_clr) begin
        r_idx <= '0;
      end else if (i_idx_inc) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // History word for tap i is (wr_ptr - i) mod NUM_TAPS; fold negatives back up.
  assign w_hist_ext = (r_wr_ptr >= r_idx) ? ({1'b0, r_wr_ptr} - {1'b0, r_idx})
                                          : ({1'b0, r_wr_ptr} + (IW + 1)'(NUM_TAPS)
                                             - {1'b0, r_idx});

  assign o_idx    = r_idx;
  assign o_wr_a   = AW'({r_wr_ptr, 2'b00});
  assign o_idx_a  = AW'({r_idx, 2'b00});
  assign o_hist_a = AW'({w_hist_ext[IW-1:0], 2'b00});

  logic w_unused_hist_msb;
  assign w_unused_hist_msb = w_hist_ext[IW];

endmodule

// File: rtl/fir_stream_engine.sv
// Streaming FIR engine: stores each input in a circular data BRAM, runs a
// NUM_TAPS-long multiply-accumulate over tap/data BRAM reads and emits one result.
module fir_stream_engine
  import fir_stream_engine_pkg::*;
#(
  parameter int unsigned NUM_TAPS = NUM_TAPS_DEFAULT,
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 12
) (
  input  logic          axis_clk,
  input  logic          axis_rst,
  input  logic          ap_start,
  input  logic [31:0]   data_length,
  output logic          ap_idle,
  output logic          ap_done,
  input  logic          ss_tvalid,
  input  logic [DW-1:0] ss_tdata,
  input  logic          ss_tlast,
  output logic          ss_tready,
  output logic          sm_tvalid,
  output logic [DW-1:0] sm_tdata,
  output logic          sm_tlast,
  input  logic          sm_tready,
  output logic          tap_EN,
  output logic [3:0]    tap_WE,
  output logic [AW-1:0] tap_A,
  input  logic [DW-1:0] tap_Do,
  output logic          data_EN,
  output logic [3:0]    data_WE,
  output logic [AW-1:0] data_A,
  output logic [DW-1:0] data_Di,
  input  logic [DW-1:0] data_Do
);

  localparam int unsigned IW = $clog2(NUM_TAPS + 1);

  state_e        r_state;
  logic [31:0]   r_len;
  logic [31:0]   r_cnt;
  logic [DW-1:0] r_acc;

  logic [IW-1:0] w_idx;
  logic [AW-1:0] w_wr_a;
  logic [AW-1:0] w_idx_a;
  logic [AW-1:0] w_hist_a;
  logic          w_start;
  logic          w_in_hs;
  logic          w_out_hs;
  logic          w_last;
  logic          w_tap_rd;
  logic [DW-1:0] w_prod;

  assign w_start  = (r_state == StIdle) && ap_start;
  assign w_in_hs  = (r_state == StIn) && ss_tvalid;
  assign w_out_hs = (r_state == StOut) && sm_tready;
  assign w_last   = (r_cnt == r_len - 32'd1);
  assign w_tap_rd = (r_state == StMac) && (w_idx < IW'(NUM_TAPS));
  assign w_prod   = tap_Do * data_Do;

  fir_stream_engine_addr_gen #(
    .NUM_TAPS (NUM_TAPS),
    .AW       (AW),
    .IW       (IW)
  ) u_addr_gen (
    .i_clk     (axis_clk),
    .i_rst     (axis_rst),
    .i_ptr_clr (w_start),
    .i_ptr_adv (w_out_hs),
    .i_idx_clr (w_start || w_in_hs),
    .i_idx_inc ((r_state == StClear) || (r_state == StMac)),
    .o_idx     (w_idx),
    .o_wr_a    (w_wr_a),
    .o_idx_a   (w_idx_a),
    .o_hist_a  (w_hist_a)
  );

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_state <= StIdle;
      r_len   <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (ap_start) begin
            r_len   <= data_length;
            r_cnt   <= '0;
            r_state <= StClear;
          end
        end
        StClear: begin
          if (w_idx == IW'(NUM_TAPS - 1)) begin
            r_state <= (r_len != 32'd0) ? StIn : StDone;
          end
        end
        StIn: begin
          if (ss_tvalid) begin
            r_acc   <= '0;
            r_state <= StMac;
          end
        end
        StMac: begin
          // Index 0 only issues reads; products arrive one cycle behind.
          if (w_idx != '0) begin
            r_acc <= r_acc + w_prod;
          end
          if (w_idx == IW'(NUM_TAPS)) begin
            r_state <= StOut;
          end
        end
        StOut: begin
          if (sm_tready) begin
            r_cnt   <= r_cnt + 32'd1;
            r_state <= w_last ? StDone : StIn;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ap_idle   = (r_state == StIdle);
  assign ap_done   = (r_state == StDone);
  assign ss_tready = (r_state == StIn);
  assign sm_tvalid = (r_state == StOut);
  assign sm_tdata  = r_acc;
  assign sm_tlast  = (r_state == StOut) && w_last;

  assign tap_EN = w_tap_rd;
  assign tap_WE = WE_NONE;
  assign tap_A  = w_tap_rd ? w_idx_a : '0;

  always_comb begin
    data_EN = 1'b0;
    data_WE = WE_NONE;
    data_A  = '0;
    data_Di = '0;
    unique case (r_state)
      StClear: begin
        data_EN = 1'b1;
        data_WE = WE_ALL;
        data_A  = w_idx_a;
      end
      StIn: begin
        data_EN = ss_tvalid;
        data_WE = ss_tvalid ? WE_ALL : WE_NONE;
        data_A  = w_wr_a;
        data_Di = ss_tdata;
      end
      StMac: begin
        data_EN = w_tap_rd;
        data_A  = w_tap_rd ? w_hist_a : '0;
      end
      default: ;
    endcase
  end

  logic w_unused_tlast;
  assign w_unused_tlast = ss_tlast;

endmodule
